// File: rtl/stream_pixel_converter_pkg.sv
// stream_pixel_converter_pkg
// Shared constants for the pixel stream converter: CSR word addresses,
// conversion mode encodings and the fixed-point luma coefficients.
package stream_pixel_converter_pkg;

   // CSR word addresses
   localparam logic [1:0] CSR_CTRL   = 2'd0;
   localparam logic [1:0] CSR_STATUS = 2'd1;
   localparam logic [1:0] CSR_PKT    = 2'd2;
   localparam logic [1:0] CSR_PIX    = 2'd3;

   // Bit position of the FIFO occupancy field inside STATUS
   localparam int unsigned STATUS_COUNT_LSB = 8;

   // Conversion modes as held in CTRL[2:1]
   typedef enum logic [1:0] {
      MODE_TRUNC     = 2'd0,
      MODE_GREY      = 2'd1,
      MODE_RAW       = 2'd2,
      MODE_TRUNC_ALT = 2'd3
   } mode_e;

   // Luma weights in 1/256 units; they sum to 256 so Y never exceeds full scale
   localparam int unsigned GREY_R_COEF = 77;
   localparam int unsigned GREY_G_COEF = 150;
   localparam int unsigned GREY_B_COEF = 29;
   localparam int unsigned GREY_SHIFT  = 8;

endpackage : stream_pixel_converter_pkg

// File: rtl/stream_fifo.sv
// stream_fifo
// Synchronous FIFO with a fall-through head: the oldest entry is always
// visible on rd_data, and rd_data reads zero while the FIFO is empty.
//   clk, rst  : clock, asynchronous active-high reset (clears all contents)
//   wr_en     : push wr_data (ignored when full)
//   rd_en     : pop the head entry (ignored when empty)
//   rd_data   : head entry
//   count     : current occupancy, 0..DEPTH
module stream_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
   always_comb begin
      do_wr    = wr_en && (count_q < CW'(DEPTH));
      do_rd    = rd_en && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_wr) - CW'(do_rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count   = count_q;

endmodule : stream_fifo

// File: rtl/stream_pixel_converter.sv
// stream_pixel_converter
// Converts a {R,G,B} pixel stream of BPC bits per channel into a narrower
// {R,G,B} format (truncate, greyscale or raw pass-through), buffering the
// converted beats in an output FIFO. A small CSR block controls the gate and
// mode and exposes packet/pixel counters.
//   clock, reset             : sole clock, asynchronous active-high reset
//   io_S_AVALON_*            : CSR slave (combinational read, write on edge)
//   io_S_STREAM_stream_in_*  : input pixel stream (valid/ready, SOP/EOP/empty)
//   io_S_STREAM_stream_out_* : output pixel stream from the FIFO head
module stream_pixel_converter #(
   parameter int unsigned BPC     = 8,
   parameter int unsigned R_W     = 5,
   parameter int unsigned G_W     = 6,
   parameter int unsigned B_W     = 5,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned EMPTY_W = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   // CSR slave
   input  logic [1:0]                  io_S_AVALON_address,
   input  logic                        io_S_AVALON_chipselect,
   input  logic                        io_S_AVALON_write_n,
   input  logic [31:0]                 io_S_AVALON_writedata,
   output logic [31:0]                 io_S_AVALON_readdata,
   // Input stream
   input  logic [3*BPC-1:0]            io_S_STREAM_stream_in_data,
   input  logic                        io_S_STREAM_stream_in_startofpacket,
   input  logic                        io_S_STREAM_stream_in_endofpacket,
   input  logic                        io_S_STREAM_stream_in_valid,
   input  logic [EMPTY_W-1:0]          io_S_STREAM_stream_in_empty,
   output logic                        io_S_STREAM_stream_in_ready,
   // Output stream
   output logic [R_W+G_W+B_W-1:0]      io_S_STREAM_stream_out_data,
   output logic                        io_S_STREAM_stream_out_startofpacket,
   output logic                        io_S_STREAM_stream_out_endofpacket,
   output logic                        io_S_STREAM_stream_out_valid,
   output logic [EMPTY_W-1:0]          io_S_STREAM_stream_out_empty,
   input  logic                        io_S_STREAM_stream_out_ready
);

   import stream_pixel_converter_pkg::*;

   localparam int unsigned OUT_W = R_W + G_W + B_W;
   localparam int unsigned YW    = BPC + GREY_SHIFT;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam int unsigned FW    = OUT_W + EMPTY_W + 2;

   // Control / status state
   logic          enable_q, enable_d;
   mode_e         mode_q, mode_d;
   logic          in_packet_q, in_packet_d;
   mode_e         mode_lat_q, mode_lat_d;
   logic [31:0]   pkt_cnt_q, pkt_cnt_d;
   logic [31:0]   pix_cnt_q, pix_cnt_d;

   // Datapath
   logic [BPC-1:0]   chan_r, chan_g, chan_b;
   logic [YW-1:0]    y_full;
   logic [BPC-1:0]   y;
   mode_e            eff_mode;
   logic [OUT_W-1:0] conv_data;
   logic [FW-1:0]    fifo_wr_data, fifo_rd_data;
   logic [CW-1:0]    fifo_count;

   logic csr_wr, in_ready_c, in_fire, out_valid_c, out_fire;
   logic out_eop;

   assign csr_wr      = io_S_AVALON_chipselect && !io_S_AVALON_write_n;
   assign out_valid_c = (fifo_count != '0);
   // Ready depends only on registered occupancy, so a pop at full does not open it
   assign in_ready_c  = (enable_q || in_packet_q) && (fifo_count < CW'(DEPTH));
   assign in_fire     = io_S_STREAM_stream_in_valid && in_ready_c;
   assign out_fire    = out_valid_c && io_S_STREAM_stream_out_ready;

   // Pixel conversion; an SOP beat uses the live CTRL mode it is about to latch
   always_comb begin
      chan_r   = io_S_STREAM_stream_in_data[3*BPC-1 -: BPC];
      chan_g   = io_S_STREAM_stream_in_data[2*BPC-1 -: BPC];
      chan_b   = io_S_STREAM_stream_in_data[BPC-1:0];
      y_full   = YW'(GREY_R_COEF) * YW'(chan_r)
               + YW'(GREY_G_COEF) * YW'(chan_g)
               + YW'(GREY_B_COEF) * YW'(chan_b);
      y        = y_full[YW-1 -: BPC];
      eff_mode = io_S_STREAM_stream_in_startofpacket ? mode_q : mode_lat_q;
      case (eff_mode)
         MODE_GREY: conv_data = {y[BPC-1 -: R_W], y[BPC-1 -: G_W], y[BPC-1 -: B_W]};
         MODE_RAW:  conv_data = io_S_STREAM_stream_in_data[OUT_W-1:0];
         default:   conv_data = {chan_r[BPC-1 -: R_W], chan_g[BPC-1 -: G_W],
                                 chan_b[BPC-1 -: B_W]};
      endcase
      fifo_wr_data = {io_S_STREAM_stream_in_startofpacket,
                      io_S_STREAM_stream_in_endofpacket,
                      io_S_STREAM_stream_in_empty,
                      conv_data};
   end

   stream_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .wr_en   (in_fire),
      .wr_data (fifo_wr_data),
      .rd_en   (out_fire),
      .rd_data (fifo_rd_data),
      .count   (fifo_count)
   );

   assign out_eop = fifo_rd_data[FW-2];

   // Next-state for CTRL, packet tracking and counters
   always_comb begin
      enable_d    = enable_q;
      mode_d      = mode_q;
      in_packet_d = in_packet_q;
      mode_lat_d  = mode_lat_q;
      pkt_cnt_d   = pkt_cnt_q;
      pix_cnt_d   = pix_cnt_q;

      if (csr_wr && (io_S_AVALON_address == CSR_CTRL)) begin
         enable_d = io_S_AVALON_writedata[0];
         mode_d   = mode_e'(io_S_AVALON_writedata[2:1]);
      end

      if (in_fire) begin
         if (io_S_STREAM_stream_in_startofpacket) begin
            mode_lat_d = mode_q;
         end
         if (io_S_STREAM_stream_in_endofpacket) begin
            in_packet_d = 1'b0;
         end else if (io_S_STREAM_stream_in_startofpacket) begin
            in_packet_d = 1'b1;
         end
      end

      if (out_fire) begin
         pix_cnt_d = pix_cnt_q + 32'd1;
         if (out_eop) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
         end
      end

      // A clear request overrides a same-cycle increment
      if (csr_wr && (io_S_AVALON_address == CSR_PKT)) begin
         pkt_cnt_d = '0;
         pix_cnt_d = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enable_q    <= 1'b0;
         mode_q      <= MODE_TRUNC;
         in_packet_q <= 1'b0;
         mode_lat_q  <= MODE_TRUNC;
         pkt_cnt_q   <= '0;
         pix_cnt_q   <= '0;
      end else begin
         enable_q    <= enable_d;
         mode_q      <= mode_d;
         in_packet_q <= in_packet_d;
         mode_lat_q  <= mode_lat_d;
         pkt_cnt_q   <= pkt_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
      end
   end

   // Combinational CSR read mux
   always_comb begin
      io_S_AVALON_readdata = '0;
      case (io_S_AVALON_address)
         CSR_CTRL: begin
            io_S_AVALON_readdata[0]   = enable_q;
            io_S_AVALON_readdata[2:1] = mode_q;
         end
         CSR_STATUS: begin
            io_S_AVALON_readdata[0]                       = in_packet_q;
            io_S_AVALON_readdata[1]                       = out_valid_c;
            io_S_AVALON_readdata[STATUS_COUNT_LSB +: CW]  = fifo_count;
         end
         CSR_PKT: io_S_AVALON_readdata = pkt_cnt_q;
         default: io_S_AVALON_readdata = pix_cnt_q;
      endcase
   end

   assign io_S_STREAM_stream_in_ready          = in_ready_c;
   assign io_S_STREAM_stream_out_valid         = out_valid_c;
   assign io_S_STREAM_stream_out_startofpacket = fifo_rd_data[FW-1];
   assign io_S_STREAM_stream_out_endofpacket   = out_eop;
   assign io_S_STREAM_stream_out_empty         = fifo_rd_data[OUT_W +: EMPTY_W];
   assign io_S_STREAM_stream_out_data          = fifo_rd_data[OUT_W-1:0];

   // Bits that are intentionally not consumed
   logic unused_ok;
   assign unused_ok = ^{io_S_AVALON_writedata[31:3], y_full[GREY_SHIFT-1:0], y};

endmodule : stream_pixel_converter

// File: tb/tb_stream_pixel_converter.sv
// tb_stream_pixel_converter
// Randomised and directed stimulus against a queue-based reference model of
// the converter (expected output beats, CTRL, packet state, counters).
module tb_stream_pixel_converter;

   localparam int unsigned BPC     = 8;
   localparam int unsigned R_W     = 5;
   localparam int unsigned G_W     = 6;
   localparam int unsigned B_W     = 5;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned EMPTY_W = 2;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [1:0] empty;
      logic [15:0] data;
   } beat_t;

   logic        clock, reset;
   logic [1:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata, readdata;
   logic [23:0] in_data;
   logic        in_sop, in_eop, in_valid, in_ready;
   logic [1:0]  in_empty;
   logic [15:0] out_data;
   logic        out_sop, out_eop, out_valid, out_ready;
   logic [1:0]  out_empty;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model state
   beat_t       exp_q[$];
   logic        m_enable, m_in_pkt;
   logic [1:0]  m_mode, m_lat;
   logic [31:0] m_pkt, m_pix;

   stream_pixel_converter #(
      .BPC(BPC), .R_W(R_W), .G_W(G_W), .B_W(B_W), .DEPTH(DEPTH), .EMPTY_W(EMPTY_W)
   ) dut (
      .clock                                (clock),
      .reset                                (reset),
      .io_S_AVALON_address                  (address),
      .io_S_AVALON_chipselect               (chipselect),
      .io_S_AVALON_write_n                  (write_n),
      .io_S_AVALON_writedata                (writedata),
      .io_S_AVALON_readdata                 (readdata),
      .io_S_STREAM_stream_in_data           (in_data),
      .io_S_STREAM_stream_in_startofpacket  (in_sop),
      .io_S_STREAM_stream_in_endofpacket    (in_eop),
      .io_S_STREAM_stream_in_valid          (in_valid),
      .io_S_STREAM_stream_in_empty          (in_empty),
      .io_S_STREAM_stream_in_ready          (in_ready),
      .io_S_STREAM_stream_out_data          (out_data),
      .io_S_STREAM_stream_out_startofpacket (out_sop),
      .io_S_STREAM_stream_out_endofpacket   (out_eop),
      .io_S_STREAM_stream_out_valid         (out_valid),
      .io_S_STREAM_stream_out_empty         (out_empty),
      .io_S_STREAM_stream_out_ready         (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Pixel conversion from the arithmetic rules
   function automatic logic [15:0] model_convert(input logic [1:0] mode, input logic [23:0] d);
      int unsigned r, g, b, y, ro, go, bo;
      r = 32'(d) / 65536;
      g = (32'(d) / 256) % 256;
      b = 32'(d) % 256;
      if (mode == 2'd2) return d[15:0];
      if (mode == 2'd1) begin
         y  = (77 * r + 150 * g + 29 * b) / 256;
         ro = y >> (BPC - R_W);
         go = y >> (BPC - G_W);
         bo = y >> (BPC - B_W);
      end else begin
         ro = r >> (BPC - R_W);
         go = g >> (BPC - G_W);
         bo = b >> (BPC - B_W);
      end
      return 16'(ro * (1 << (G_W + B_W)) + go * (1 << B_W) + bo);
   endfunction

   function automatic logic [31:0] model_csr(input logic [1:0] a);
      case (a)
         2'd0:    return {29'd0, m_mode, m_enable};
         2'd1:    return 32'(m_in_pkt) | (32'(exp_q.size() != 0) << 1) | (32'(exp_q.size()) << 8);
         2'd2:    return m_pkt;
         default: return m_pix;
      endcase
   endfunction

   // Monitor: compare current state at the falling edge, then advance the
   // model to the state expected after the next rising edge.
   always @(negedge clock) begin
      logic  in_fire, out_fire;
      logic [1:0] used_mode;
      beat_t b;
      if (reset) begin
         check_eq("rst_in_ready", 32'(in_ready), 32'd0);
         check_eq("rst_out_valid", 32'(out_valid), 32'd0);
         check_eq("rst_out_beat", 32'({out_sop, out_eop, out_empty, out_data}), 32'd0);
         exp_q.delete();
         m_enable = 0; m_in_pkt = 0; m_mode = 0; m_lat = 0; m_pkt = 0; m_pix = 0;
      end else begin
         check_eq("in_ready", 32'(in_ready),
                  32'((m_enable || m_in_pkt) && (exp_q.size() < DEPTH)));
         check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         if (out_valid && exp_q.size() != 0)
            check_eq("out_beat", 32'({out_sop, out_eop, out_empty, out_data}), 32'(exp_q[0]));
         in_fire  = in_valid && in_ready;
         out_fire = out_valid && out_ready;
         if (out_fire && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            m_pix++;
            if (b.eop) m_pkt++;
         end
         if (chipselect && !write_n && address == 2'd2) begin
            m_pkt = 0; m_pix = 0;
         end
         if (in_fire) begin
            if (in_sop) m_lat = m_mode;
            used_mode = m_lat;
            b.sop = in_sop; b.eop = in_eop; b.empty = in_empty;
            b.data = model_convert(used_mode, in_data);
            exp_q.push_back(b);
            if (in_eop) m_in_pkt = 0;
            else if (in_sop) m_in_pkt = 1;
         end
         if (chipselect && !write_n && address == 2'd0) begin
            m_enable = writedata[0];
            m_mode   = writedata[2:1];
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1; write_n = 0;
      tick();
      chipselect = 0; write_n = 1;
   endtask

   task automatic csr_rd(input logic [1:0] a);
      address = a;
      #1;
      check_eq($sformatf("csr_rd%0d", a), readdata, model_csr(a));
   endtask

   task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop,
                            input logic [1:0] emp);
      bit done = 0;
      in_data = d; in_sop = sop; in_eop = eop; in_empty = emp; in_valid = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (in_ready) done = 1;
         @(posedge clock);
         #1;
      end
      in_valid = 0;
      if (!done) check_eq("send_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned idx, beat_idx, pkt_len;
      logic acc;
      reset = 1; address = 0; chipselect = 0; write_n = 1; writedata = 0;
      in_data = 0; in_sop = 0; in_eop = 0; in_valid = 0; in_empty = 0; out_ready = 0;
      m_enable = 0; m_in_pkt = 0; m_mode = 0; m_lat = 0; m_pkt = 0; m_pix = 0;

      // Reset, then idle with CTRL=0
      repeat (3) tick();
      reset = 0;
      tick();
      check_eq("idle_in_ready", 32'(in_ready), 32'd0);
      check_eq("idle_out_valid", 32'(out_valid), 32'd0);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check_eq($sformatf("idle_rd%0d", a), readdata, 32'd0);
      end

      // Single-beat truncate packet
      csr_wr(2'd0, 32'd1);
      out_ready = 1;
      send_beat(24'h666666, 1, 1, 2'd1);
      check_eq("t1_out_valid", 32'(out_valid), 32'd1);
      check_eq("t1_out_data", 32'(out_data), 32'h632C);
      check_eq("t1_side", 32'({out_sop, out_eop, out_empty}), 32'b1101);
      tick();
      address = 2'd2; #1; check_eq("t1_pkt", readdata, 32'd1);
      address = 2'd3; #1; check_eq("t1_pix", readdata, 32'd1);

      // Greyscale of pure red
      csr_wr(2'd0, 32'd3);
      send_beat(24'hFF0000, 1, 1, 2'd0);
      check_eq("grey_out_data", 32'(out_data), 32'h4A69);
      tick();

      // Backpressure: FIFO fills at DEPTH, then drains in order (raw mode)
      csr_wr(2'd0, 32'd5);
      out_ready = 0;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         in_data = 24'(32'hA50000 + idx); in_sop = (idx == 0); in_eop = (idx == DEPTH + 1);
         in_empty = 2'(idx); in_valid = 1;
         @(negedge clock); acc = in_ready;
         @(posedge clock); #1;
         if (acc) idx++;
      end
      check_eq("full_accepted", idx, DEPTH);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      csr_rd(2'd1);
      out_ready = 1;
      for (int c = 0; c < 20 && idx < DEPTH + 2; c++) begin
         in_data = 24'(32'hA50000 + idx); in_sop = (idx == 0); in_eop = (idx == DEPTH + 1);
         in_empty = 2'(idx); in_valid = 1;
         @(negedge clock); acc = in_ready;
         @(posedge clock); #1;
         if (acc) idx++;
      end
      in_valid = 0;
      repeat (DEPTH + 3) tick();
      check_eq("bp_drained", exp_q.size(), 32'd0);
      csr_rd(2'd3);

      // Disable mid-packet: packet completes in its latched mode, then gate closes
      csr_wr(2'd0, 32'd3);
      send_beat(24'h123456, 1, 0, 2'd0);
      csr_wr(2'd0, 32'd4);
      send_beat(24'h80C0F0, 0, 0, 2'd0);
      send_beat(24'h0F1E2D, 0, 1, 2'd2);
      tick();
      check_eq("mid_in_ready", 32'(in_ready), 32'd0);
      csr_rd(2'd0);
      csr_rd(2'd1);
      repeat (3) tick();
      csr_wr(2'd2, 32'hDEAD);
      address = 2'd2; #1; check_eq("clr_pkt", readdata, 32'd0);
      address = 2'd3; #1; check_eq("clr_pix", readdata, 32'd0);

      // Reset with beats in the FIFO
      csr_wr(2'd0, 32'd1);
      out_ready = 0;
      send_beat(24'h111111, 1, 0, 2'd0);
      send_beat(24'h222222, 0, 0, 2'd0);
      check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1;
      #1;
      check_eq("rst_imm_valid", 32'(out_valid), 32'd0);
      check_eq("rst_imm_ready", 32'(in_ready), 32'd0);
      repeat (2) tick();
      reset = 0;
      out_ready = 1;
      repeat (3) tick();
      check_eq("post_rst_valid", 32'(out_valid), 32'd0);
      csr_rd(2'd1);

      // Randomised traffic with random backpressure, mode changes and clears
      csr_wr(2'd0, 32'd1);
      beat_idx = 0; pkt_len = 2; in_valid = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clock); acc = in_valid && in_ready;
         @(posedge clock); #1;
         chipselect = 0; write_n = 1;
         if (acc) begin
            beat_idx++;
            if (beat_idx == pkt_len) begin
               beat_idx = 0;
               pkt_len = $urandom_range(1, 4);
            end
         end
         if (acc || !in_valid) begin
            in_valid = ($urandom % 4) != 0;
            in_data  = 24'($urandom);
            in_sop   = (beat_idx == 0);
            in_eop   = (beat_idx == pkt_len - 1);
            in_empty = 2'($urandom);
         end
         out_ready = ($urandom % 3) != 0;
         if ($urandom % 16 == 0) begin
            address = 2'd0; writedata = 32'd1 | 32'(($urandom % 4) << 1);
            chipselect = 1; write_n = 0;
         end else if ($urandom % 64 == 0) begin
            address = 2'd2; writedata = $urandom; chipselect = 1; write_n = 0;
         end else begin
            address = 2'($urandom);
            #1;
            check_eq("rnd_csr", readdata, model_csr(address));
         end
      end
      chipselect = 0; write_n = 1; in_valid = 0; out_ready = 1;
      repeat (DEPTH + 4) tick();
      check_eq("rnd_drained", exp_q.size(), 32'd0);
      for (int a = 0; a < 4; a++) csr_rd(2'(a));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_stream_pixel_converter
